// File: rtl/m3_pkg.sv
// Shared constants for the milestone-3 decoder path: zig-zag scan tables and
// the power-of-two dequantization shifts for Q0/Q1, indexed by diagonal row+col.
package m3_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam logic [5:0] LAST_INDEX = 6'(BLOCK_SIZE - 1);

  localparam logic [2:0] ZIGZAG_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZIGZAG_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

  localparam logic [2:0] SHIFT_Q0 [15] = '{
    3'd3, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6,
    3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6
  };

  localparam logic [2:0] SHIFT_Q1 [15] = '{
    3'd3, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
    3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4
  };

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] shift;
  } zz_entry_t;

endpackage

// File: rtl/m3_dequant_writer_if.sv
// Coefficient input and DP-RAM write bus of the dequant writer.
// enable is a valid with no ready: every enabled cycle is consumed, no backpressure.
interface m3_dequant_writer_if;
  logic        restart;
  logic        enable;
  logic        quantization_matrix;
  logic [8:0]  input_bits;
  logic [15:0] result;
  logic        wren_a;
  logic [7:0]  address_a;
  logic        block_done;
  logic        bank;

  modport master (
    output restart, enable, quantization_matrix, input_bits,
    input  result, wren_a, address_a, block_done, bank
  );

  modport slave (
    input  restart, enable, quantization_matrix, input_bits,
    output result, wren_a, address_a, block_done, bank
  );
endinterface

// File: rtl/zigzag_lut.sv
// Combinational map from scan position and matrix select to row, col and shift.
module zigzag_lut
  import m3_pkg::*;
(
  input  logic [5:0] zz_index_i,
  input  logic       qmatrix_i,
  output zz_entry_t  entry_o
);

  logic [2:0] row;
  logic [2:0] col;
  logic [3:0] diag;

  always_comb begin
    row  = ZIGZAG_ROW[zz_index_i];
    col  = ZIGZAG_COL[zz_index_i];
    diag = {1'b0, row} + {1'b0, col};
    entry_o.row   = row;
    entry_o.col   = col;
    entry_o.shift = qmatrix_i ? SHIFT_Q1[diag] : SHIFT_Q0[diag];
  end

endmodule

// File: rtl/m3_dequant_writer.sv
// Dequantizes zig-zag ordered coefficients and writes them row-major into one
// of two ping-pong 64-word banks of the coefficient DP RAM.
module m3_dequant_writer
  import m3_pkg::*;
#(
  parameter logic [7:0] BANK_BASE = 8'd0
) (
  input logic               CLOCK_50_I,
  input logic               resetn,
  m3_dequant_writer_if.slave io
);

  logic [5:0]  zz_q, zz_d;
  logic        bank_q, bank_d;
  logic [15:0] result_q, result_d;
  logic        wren_q, wren_d;
  logic [7:0]  addr_q, addr_d;
  logic        done_q, done_d;

  zz_entry_t   entry;
  logic [15:0] coef_ext;

  zigzag_lut u_lut (
    .zz_index_i (zz_q),
    .qmatrix_i  (io.quantization_matrix),
    .entry_o    (entry)
  );

  assign coef_ext = {{7{io.input_bits[8]}}, io.input_bits};

  // result/address hold when idle; only the strobes fall back to zero
  always_comb begin
    zz_d     = zz_q;
    bank_d   = bank_q;
    result_d = result_q;
    addr_d   = addr_q;
    wren_d   = 1'b0;
    done_d   = 1'b0;
    if (io.restart) begin
      zz_d   = 6'd0;
      bank_d = 1'b0;
    end else if (io.enable) begin
      wren_d   = 1'b1;
      result_d = coef_ext << entry.shift;
      addr_d   = BANK_BASE + {1'b0, bank_q, entry.row, entry.col};
      zz_d     = zz_q + 6'd1;
      if (zz_q == LAST_INDEX) begin
        bank_d = ~bank_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      zz_q     <= 6'd0;
      bank_q   <= 1'b0;
      result_q <= 16'd0;
      wren_q   <= 1'b0;
      addr_q   <= BANK_BASE;
      done_q   <= 1'b0;
    end else begin
      zz_q     <= zz_d;
      bank_q   <= bank_d;
      result_q <= result_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  assign io.result     = result_q;
  assign io.wren_a     = wren_q;
  assign io.address_a  = addr_q;
  assign io.block_done = done_q;
  assign io.bank       = bank_q;

endmodule

// File: tb/tb_m3_dequant_writer.sv
// Directed bench for m3_dequant_writer: scan addressing, Q0/Q1 shifts, bank
// ping-pong, gaps, restart and asynchronous reset.
module tb_m3_dequant_writer;

  localparam logic [7:0] BASE = 8'd0;

  logic clk = 1'b0;
  logic resetn;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #10 clk = ~clk;

  m3_dequant_writer_if dut_if ();

  m3_dequant_writer #(.BANK_BASE(BASE)) dut (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .io         (dut_if)
  );

  // raster position of each zig-zag index
  int raster [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  int sh_q0 [15] = '{3, 2, 3, 4, 5, 5, 6, 6, 6, 6, 6, 6, 6, 6, 6};
  int sh_q1 [15] = '{3, 1, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4, 4};

  function automatic logic [15:0] exp_coef(input logic [8:0] v, input logic q, input int idx);
    logic signed [8:0] sv;
    int r, s, sh, x;
    sv = v;
    r  = raster[idx];
    s  = r / 8 + r % 8;
    sh = q ? sh_q1[s] : sh_q0[s];
    x  = int'(sv) * (1 << sh);
    return x[15:0];
  endfunction

  // ---- driver tasks ----
  task automatic drive_write(input logic [8:0] v, input logic q);
    dut_if.enable = 1'b1;
    dut_if.input_bits = v;
    dut_if.quantization_matrix = q;
    @(posedge clk); #1;
    dut_if.enable = 1'b0;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic drive_restart(input logic en, input logic [8:0] v);
    dut_if.restart = 1'b1;
    dut_if.enable = en;
    dut_if.input_bits = v;
    @(posedge clk); #1;
    dut_if.restart = 1'b0;
    dut_if.enable = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    #25;
    tests_run++;
    if (dut_if.result !== 16'd0) begin tests_failed++; $display("FAIL reset_result got %h exp 0000", dut_if.result); end
    tests_run++;
    if (dut_if.wren_a !== 1'b0) begin tests_failed++; $display("FAIL reset_wren got %b exp 0", dut_if.wren_a); end
    tests_run++;
    if (dut_if.address_a !== BASE) begin tests_failed++; $display("FAIL reset_addr got %h exp %h", dut_if.address_a, BASE); end
    tests_run++;
    if (dut_if.block_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", dut_if.block_done); end
    tests_run++;
    if (dut_if.bank !== 1'b0) begin tests_failed++; $display("FAIL reset_bank got %b exp 0", dut_if.bank); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_q0_start();
    drive_write(9'd5, 1'b0);
    tests_run++;
    if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== 8'd0 || dut_if.result !== 16'd40) begin
      tests_failed++; $display("FAIL q0_idx0 got wren=%b addr=%h res=%h exp 1/00/0028", dut_if.wren_a, dut_if.address_a, dut_if.result);
    end
    drive_write(9'h1FF, 1'b0);
    tests_run++;
    if (dut_if.address_a !== 8'd1 || dut_if.result !== 16'hFFFC) begin
      tests_failed++; $display("FAIL q0_idx1 got addr=%h res=%h exp 01/fffc", dut_if.address_a, dut_if.result);
    end
    drive_write(9'd3, 1'b0);
    tests_run++;
    if (dut_if.address_a !== 8'd8 || dut_if.result !== 16'd12 || dut_if.block_done !== 1'b0) begin
      tests_failed++; $display("FAIL q0_idx2 got addr=%h res=%h done=%b exp 08/000c/0", dut_if.address_a, dut_if.result, dut_if.block_done);
    end
    drive_idle();
    tests_run++;
    if (dut_if.wren_a !== 1'b0) begin tests_failed++; $display("FAIL idle_no_write got %b exp 0", dut_if.wren_a); end
    drive_restart(1'b0, 9'd0);
    tests_run++;
    if (dut_if.wren_a !== 1'b0 || dut_if.bank !== 1'b0) begin
      tests_failed++; $display("FAIL plain_restart got wren=%b bank=%b exp 0/0", dut_if.wren_a, dut_if.bank);
    end
  endtask

  task automatic test_full_block_q1();
    logic [8:0] v;
    for (int k = 0; k < 64; k++) begin
      v = (k == 63) ? 9'd255 : 9'(k * 7 - 200);
      drive_write(v, 1'b1);
      tests_run++;
      if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== BASE + 8'(raster[k]) || dut_if.result !== exp_coef(v, 1'b1, k)) begin
        tests_failed++;
        $display("FAIL blk1_write idx=%0d got wren=%b addr=%h res=%h exp 1/%h/%h", k, dut_if.wren_a,
                 dut_if.address_a, dut_if.result, BASE + 8'(raster[k]), exp_coef(v, 1'b1, k));
      end
      if (k < 63) begin
        tests_run++;
        if (dut_if.block_done !== 1'b0 || dut_if.bank !== 1'b0) begin
          tests_failed++; $display("FAIL blk1_midblock idx=%0d got done=%b bank=%b exp 0/0", k, dut_if.block_done, dut_if.bank);
        end
      end
    end
    tests_run++;
    if (dut_if.address_a !== 8'd63 || dut_if.result !== 16'h0FF0 || dut_if.block_done !== 1'b1 || dut_if.bank !== 1'b1) begin
      tests_failed++; $display("FAIL blk1_last got addr=%h res=%h done=%b bank=%b exp 3f/0ff0/1/1",
                               dut_if.address_a, dut_if.result, dut_if.block_done, dut_if.bank);
    end
  endtask

  task automatic test_second_block_gaps();
    logic [8:0] v;
    logic       q;
    int         gap;
    drive_write(9'h100, 1'b0);
    tests_run++;
    if (dut_if.address_a !== 8'd64 || dut_if.result !== 16'hF800 || dut_if.block_done !== 1'b0 || dut_if.bank !== 1'b1) begin
      tests_failed++; $display("FAIL blk2_first got addr=%h res=%h done=%b bank=%b exp 40/f800/0/1",
                               dut_if.address_a, dut_if.result, dut_if.block_done, dut_if.bank);
    end
    for (int k = 1; k < 20; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        drive_idle();
        tests_run++;
        if (dut_if.wren_a !== 1'b0) begin tests_failed++; $display("FAIL gap_write idx=%0d got %b exp 0", k, dut_if.wren_a); end
      end
      v = 9'($urandom_range(0, 511));
      q = 1'($urandom_range(0, 1));
      drive_write(v, q);
      tests_run++;
      if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== BASE + 8'd64 + 8'(raster[k]) || dut_if.result !== exp_coef(v, q, k)) begin
        tests_failed++;
        $display("FAIL blk2_write idx=%0d got wren=%b addr=%h res=%h exp 1/%h/%h", k, dut_if.wren_a,
                 dut_if.address_a, dut_if.result, BASE + 8'd64 + 8'(raster[k]), exp_coef(v, q, k));
      end
    end
  endtask

  task automatic test_restart_mid_block();
    drive_restart(1'b1, 9'd100);
    tests_run++;
    if (dut_if.wren_a !== 1'b0 || dut_if.block_done !== 1'b0 || dut_if.bank !== 1'b0) begin
      tests_failed++; $display("FAIL restart_drop got wren=%b done=%b bank=%b exp 0/0/0", dut_if.wren_a, dut_if.block_done, dut_if.bank);
    end
    drive_write(9'd2, 1'b0);
    tests_run++;
    if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== 8'd0 || dut_if.result !== 16'd16) begin
      tests_failed++; $display("FAIL restart_next got wren=%b addr=%h res=%h exp 1/00/0010", dut_if.wren_a, dut_if.address_a, dut_if.result);
    end
  endtask

  task automatic test_async_reset();
    drive_write(9'd1, 1'b1);
    tests_run++;
    if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== 8'd1 || dut_if.result !== 16'd2) begin
      tests_failed++; $display("FAIL pre_reset_write got wren=%b addr=%h res=%h exp 1/01/0002", dut_if.wren_a, dut_if.address_a, dut_if.result);
    end
    #4 resetn = 1'b0;
    #1;
    tests_run++;
    if (dut_if.wren_a !== 1'b0 || dut_if.address_a !== BASE || dut_if.result !== 16'd0 ||
        dut_if.block_done !== 1'b0 || dut_if.bank !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset got wren=%b addr=%h res=%h done=%b bank=%b exp 0/%h/0000/0/0",
                               dut_if.wren_a, dut_if.address_a, dut_if.result, dut_if.block_done, dut_if.bank, BASE);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive_write(9'd1, 1'b0);
    tests_run++;
    if (dut_if.wren_a !== 1'b1 || dut_if.address_a !== BASE || dut_if.result !== 16'd8) begin
      tests_failed++; $display("FAIL post_reset_idx0 got wren=%b addr=%h res=%h exp 1/%h/0008", dut_if.wren_a, dut_if.address_a, dut_if.result, BASE);
    end
    drive_write(9'd1, 1'b0);
    tests_run++;
    if (dut_if.address_a !== BASE + 8'd1 || dut_if.result !== 16'd4) begin
      tests_failed++; $display("FAIL post_reset_idx1 got addr=%h res=%h exp %h/0004", dut_if.address_a, dut_if.result, BASE + 8'd1);
    end
  endtask

  initial begin
    resetn = 1'b0;
    dut_if.restart = 1'b0;
    dut_if.enable = 1'b0;
    dut_if.quantization_matrix = 1'b0;
    dut_if.input_bits = 9'd0;
    test_reset();
    test_q0_start();
    test_full_block_q1();
    test_second_block_gaps();
    test_restart_mid_block();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
